// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: compacts NRET-wide RVFI retirements into a FIFO
// and emits one instruction per valid/ready transfer, with order/drop checks.
module rvfi_retire_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NRET-1:0]        valid_i,
  input  logic [NRET*64-1:0]     order_i,
  input  logic [NRET*ILEN-1:0]   insn_i,
  input  logic [NRET-1:0]        trap_i,
  input  logic [NRET*XLEN-1:0]   pc_rdata_i,
  input  logic [NRET*XLEN-1:0]   pc_wdata_i,
  input  logic [NRET*5-1:0]      rd_addr_i,
  input  logic [NRET*XLEN-1:0]   rd_wdata_i,
  input  logic [NRET*XLEN-1:0]   mem_addr_i,
  input  logic [NRET*XLEN/8-1:0] mem_rmask_i,
  input  logic [NRET*XLEN/8-1:0] mem_wmask_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [63:0]            out_order_o,
  output logic [ILEN-1:0]        out_insn_o,
  output logic                   out_trap_o,
  output logic [XLEN-1:0]        out_pc_rdata_o,
  output logic [XLEN-1:0]        out_pc_wdata_o,
  output logic [4:0]             out_rd_addr_o,
  output logic [XLEN-1:0]        out_rd_wdata_o,
  output logic [XLEN-1:0]        out_mem_addr_o,
  output logic [XLEN/8-1:0]      out_mem_rmask_o,
  output logic [XLEN/8-1:0]      out_mem_wmask_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [31:0]            drop_count_o,
  output logic                   order_err_o,
  output logic [63:0]            retired_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = XLEN / 8;

  typedef struct packed {
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic            trap;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [MW-1:0]   rmask;
    logic [MW-1:0]   wmask;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          lane_e [NRET];
  logic [AW-1:0] widx [NRET];
  ent_t          head, last_q;

  logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level, free, pcnt;
  logic          push_ok, accept, pop, out_valid;

  logic          seen_q, seen_d;
  logic [63:0]   exp_q, exp_d;
  logic          err_q, err_d, ovf_q, ovf_d;
  logic [31:0]   drop_q, drop_d;
  logic [32:0]   dsum;
  logic [63:0]   ret_q, ret_d;

  // Lane compaction: each valid lane lands at wptr + (valid lanes below it).
  always_comb begin
    pcnt = '0;
    for (int i = 0; i < NRET; i++) begin
      widx[i]            = wptr_q[AW-1:0] + pcnt[AW-1:0];
      lane_e[i].order    = order_i[i*64 +: 64];
      lane_e[i].insn     = insn_i[i*ILEN +: ILEN];
      lane_e[i].trap     = trap_i[i];
      lane_e[i].pc_rdata = pc_rdata_i[i*XLEN +: XLEN];
      lane_e[i].pc_wdata = pc_wdata_i[i*XLEN +: XLEN];
      lane_e[i].rd_addr  = rd_addr_i[i*5 +: 5];
      lane_e[i].rd_wdata = rd_wdata_i[i*XLEN +: XLEN];
      lane_e[i].mem_addr = mem_addr_i[i*XLEN +: XLEN];
      lane_e[i].rmask    = mem_rmask_i[i*MW +: MW];
      lane_e[i].wmask    = mem_wmask_i[i*MW +: MW];
      pcnt               = pcnt + LW'(valid_i[i]);
    end
  end

  always_comb begin
    level     = wptr_q - rptr_q;
    free      = LW'(DEPTH) - level;
    push_ok   = pcnt <= free;
    accept    = push_ok && (pcnt != '0);
    out_valid = level != '0;
    pop       = out_valid && out_ready_i;
    head      = out_valid ? mem_q[rptr_q[AW-1:0]] : last_q;
    wptr_d    = accept ? wptr_q + pcnt : wptr_q;
    rptr_d    = pop ? rptr_q + LW'(1) : rptr_q;
    ret_d     = pop ? ret_q + 64'd1 : ret_q;
    dsum      = {1'b0, drop_q} + 33'(pcnt);
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    if (!push_ok) begin
      ovf_d  = 1'b1;
      drop_d = dsum[32] ? '1 : dsum[31:0];
    end
  end

  // Sequence tracking runs on every valid lane, stored or dropped.
  always_comb begin
    seen_d = seen_q;
    exp_d  = exp_q;
    err_d  = err_q;
    for (int i = 0; i < NRET; i++) begin
      if (valid_i[i]) begin
        if (seen_d && (order_i[i*64 +: 64] != exp_d))
          err_d = 1'b1;
        exp_d  = order_i[i*64 +: 64] + 64'd1;
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++)
      if (push_ok && valid_i[i])
        mem_q[widx[i]] <= lane_e[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
      seen_q <= 1'b0;
      exp_q  <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
      ret_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (pop)
        last_q <= head;
      seen_q <= seen_d;
      exp_q  <= exp_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      ret_q  <= ret_d;
    end
  end

  assign out_valid_o     = out_valid;
  assign out_order_o     = head.order;
  assign out_insn_o      = head.insn;
  assign out_trap_o      = head.trap;
  assign out_pc_rdata_o  = head.pc_rdata;
  assign out_pc_wdata_o  = head.pc_wdata;
  assign out_rd_addr_o   = head.rd_addr;
  assign out_rd_wdata_o  = head.rd_wdata;
  assign out_mem_addr_o  = head.mem_addr;
  assign out_mem_rmask_o = head.rmask;
  assign out_mem_wmask_o = head.wmask;
  assign level_o         = level;
  assign overflow_o      = ovf_q;
  assign drop_count_o    = drop_q;
  assign order_err_o     = err_q;
  assign retired_count_o = ret_q;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb_rvfi_retire_serializer: directed scenario tasks with hand-computed
// expectations for the RVFI retire serializer (NRET=2, DEPTH=8).
module tb_rvfi_retire_serializer;

  localparam int NRET = 2;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int MW   = XLEN / 8;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NRET-1:0]      valid_i;
  logic [NRET*64-1:0]   order_i;
  logic [NRET*ILEN-1:0] insn_i;
  logic [NRET-1:0]      trap_i;
  logic [NRET*XLEN-1:0] pc_rdata_i, pc_wdata_i, rd_wdata_i, mem_addr_i;
  logic [NRET*5-1:0]    rd_addr_i;
  logic [NRET*MW-1:0]   mem_rmask_i, mem_wmask_i;
  logic                 out_ready_i;

  logic                 out_valid_o;
  logic [63:0]          out_order_o;
  logic [ILEN-1:0]      out_insn_o;
  logic                 out_trap_o;
  logic [XLEN-1:0]      out_pc_rdata_o, out_pc_wdata_o;
  logic [4:0]           out_rd_addr_o;
  logic [XLEN-1:0]      out_rd_wdata_o, out_mem_addr_o;
  logic [MW-1:0]        out_mem_rmask_o, out_mem_wmask_o;
  logic [3:0]           level_o;
  logic                 overflow_o;
  logic [31:0]          drop_count_o;
  logic                 order_err_o;
  logic [63:0]          retired_count_o;

  int total = 0;
  int bad   = 0;

  rvfi_retire_serializer #(
    .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .valid_i(valid_i), .order_i(order_i), .insn_i(insn_i),
    .trap_i(trap_i), .pc_rdata_i(pc_rdata_i), .pc_wdata_i(pc_wdata_i),
    .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_rmask_i(mem_rmask_i),
    .mem_wmask_i(mem_wmask_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_order_o(out_order_o), .out_insn_o(out_insn_o),
    .out_trap_o(out_trap_o), .out_pc_rdata_o(out_pc_rdata_o),
    .out_pc_wdata_o(out_pc_wdata_o), .out_rd_addr_o(out_rd_addr_o),
    .out_rd_wdata_o(out_rd_wdata_o), .out_mem_addr_o(out_mem_addr_o),
    .out_mem_rmask_o(out_mem_rmask_o), .out_mem_wmask_o(out_mem_wmask_o),
    .level_o(level_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o), .order_err_o(order_err_o),
    .retired_count_o(retired_count_o)
  );

  always #5 clk = ~clk;

  task automatic clr;
    valid_i     = '0;
    order_i     = '0;
    insn_i      = '0;
    trap_i      = '0;
    pc_rdata_i  = '0;
    pc_wdata_i  = '0;
    rd_addr_i   = '0;
    rd_wdata_i  = '0;
    mem_addr_i  = '0;
    mem_rmask_i = '0;
    mem_wmask_i = '0;
  endtask

  // Lane payload is derived from its order so heads are recognisable.
  task automatic lane(input int l, input logic [63:0] ord);
    valid_i[l]                = 1'b1;
    order_i[l*64 +: 64]       = ord;
    insn_i[l*ILEN +: ILEN]    = 32'h0000_0013;
    pc_rdata_i[l*XLEN +: XLEN] = 64'h8000_0000 + ord * 4;
    pc_wdata_i[l*XLEN +: XLEN] = 64'h8000_0004 + ord * 4;
    rd_addr_i[l*5 +: 5]       = 5'(ord + 1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    clr();
    out_ready_i = 1'b0;
    rst_ni = 1'b0;
    #12;
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_valid got %0b want 0", out_valid_o);
    end
    total++;
    if ({level_o, overflow_o, drop_count_o, order_err_o} !== '0) begin
      bad++; $display("FAIL reset_status got %0h/%0b/%0d/%0b want 0",
        level_o, overflow_o, drop_count_o, order_err_o);
    end
    total++;
    if (retired_count_o !== 64'd0 || out_order_o !== 64'd0) begin
      bad++; $display("FAIL reset_counts got %0d/%0d want 0",
        retired_count_o, out_order_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single;
    clr();
    out_ready_i = 1'b1;
    lane(0, 64'd0);
    step();
    clr();
    total++;
    if (out_valid_o !== 1'b1 || out_order_o !== 64'd0) begin
      bad++; $display("FAIL single_head got v=%0b o=%0d want v=1 o=0",
        out_valid_o, out_order_o);
    end
    total++;
    if (out_pc_rdata_o !== 64'h8000_0000 || out_insn_o !== 32'h13) begin
      bad++; $display("FAIL single_fields got pc=%0h insn=%0h want 80000000/13",
        out_pc_rdata_o, out_insn_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b0 || retired_count_o !== 64'd1) begin
      bad++; $display("FAIL single_pop got v=%0b r=%0d want v=0 r=1",
        out_valid_o, retired_count_o);
    end
    total++;
    if (out_order_o !== 64'd0 || out_pc_rdata_o !== 64'h8000_0000) begin
      bad++; $display("FAIL empty_hold got o=%0d pc=%0h want 0/80000000",
        out_order_o, out_pc_rdata_o);
    end
  endtask

  task automatic test_back_to_back;
    clr();
    out_ready_i = 1'b1;
    lane(0, 64'd1);
    lane(1, 64'd2);
    step();
    clr();
    lane(1, 64'd3);
    total++;
    if (out_order_o !== 64'd1 || level_o !== 4'd2) begin
      bad++; $display("FAIL b2b_first got o=%0d l=%0d want 1/2",
        out_order_o, level_o);
    end
    step();
    clr();
    total++;
    if (out_order_o !== 64'd2 || out_pc_rdata_o !== 64'h8000_0008) begin
      bad++; $display("FAIL b2b_second got o=%0d pc=%0h want 2/80000008",
        out_order_o, out_pc_rdata_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b1 || out_order_o !== 64'd3 || order_err_o !== 1'b0) begin
      bad++; $display("FAIL b2b_third got v=%0b o=%0d e=%0b want 1/3/0",
        out_valid_o, out_order_o, order_err_o);
    end
    step();
    total++;
    if (out_valid_o !== 1'b0 || retired_count_o !== 64'd4) begin
      bad++; $display("FAIL b2b_drain got v=%0b r=%0d want 0/4",
        out_valid_o, retired_count_o);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    clr();
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clr();
      lane(0, 64'(2 * c));
      lane(1, 64'(2 * c + 1));
      step();
    end
    total++;
    if (level_o !== 4'd8 || overflow_o !== 1'b0) begin
      bad++; $display("FAIL ovf_fill got l=%0d o=%0b want 8/0",
        level_o, overflow_o);
    end
    clr();
    lane(0, 64'd8);
    lane(1, 64'd9);
    step();
    clr();
    total++;
    if (overflow_o !== 1'b1 || drop_count_o !== 32'd2 || level_o !== 4'd8) begin
      bad++; $display("FAIL ovf_drop got o=%0b d=%0d l=%0d want 1/2/8",
        overflow_o, drop_count_o, level_o);
    end
    total++;
    if (order_err_o !== 1'b0) begin
      bad++; $display("FAIL ovf_noerr got %0b want 0", order_err_o);
    end
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid_o !== 1'b1 || out_order_o !== 64'(k)) begin
        bad++; $display("FAIL ovf_drain[%0d] got v=%0b o=%0d want 1/%0d",
          k, out_valid_o, out_order_o, k);
      end
      step();
    end
    total++;
    if (out_valid_o !== 1'b0 || overflow_o !== 1'b1 || retired_count_o !== 64'd8) begin
      bad++; $display("FAIL ovf_end got v=%0b o=%0b r=%0d want 0/1/8",
        out_valid_o, overflow_o, retired_count_o);
    end
  endtask

  task automatic test_order_err;
    do_reset();
    clr();
    out_ready_i = 1'b1;
    lane(0, 64'd3);
    step();
    clr();
    lane(0, 64'd5);
    total++;
    if (out_order_o !== 64'd3 || order_err_o !== 1'b0) begin
      bad++; $display("FAIL oerr_first got o=%0d e=%0b want 3/0",
        out_order_o, order_err_o);
    end
    step();
    clr();
    total++;
    if (order_err_o !== 1'b1 || out_order_o !== 64'd5 || out_valid_o !== 1'b1) begin
      bad++; $display("FAIL oerr_second got e=%0b o=%0d v=%0b want 1/5/1",
        order_err_o, out_order_o, out_valid_o);
    end
    step();
    total++;
    if (retired_count_o !== 64'd2 || order_err_o !== 1'b1) begin
      bad++; $display("FAIL oerr_sticky got r=%0d e=%0b want 2/1",
        retired_count_o, order_err_o);
    end
  endtask

  task automatic test_full_pop_drop;
    do_reset();
    clr();
    out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clr();
      lane(0, 64'(2 * c));
      lane(1, 64'(2 * c + 1));
      step();
    end
    clr();
    out_ready_i = 1'b1;
    lane(1, 64'd8);
    step();
    clr();
    total++;
    if (level_o !== 4'd7 || drop_count_o !== 32'd1 || overflow_o !== 1'b1) begin
      bad++; $display("FAIL fullpop got l=%0d d=%0d o=%0b want 7/1/1",
        level_o, drop_count_o, overflow_o);
    end
    total++;
    if (out_order_o !== 64'd1 || order_err_o !== 1'b0) begin
      bad++; $display("FAIL fullpop_head got o=%0d e=%0b want 1/0",
        out_order_o, order_err_o);
    end
  endtask

  task automatic test_async_reset;
    out_ready_i = 1'b1;
    step();
    step();
    out_ready_i = 1'b0;
    total++;
    if (level_o !== 4'd5 || out_valid_o !== 1'b1 || retired_count_o !== 64'd3) begin
      bad++; $display("FAIL ares_pre got l=%0d v=%0b r=%0d want 5/1/3",
        level_o, out_valid_o, retired_count_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || level_o !== 4'd0 || out_order_o !== 64'd0) begin
      bad++; $display("FAIL ares_out got v=%0b l=%0d o=%0d want 0",
        out_valid_o, level_o, out_order_o);
    end
    total++;
    if ({overflow_o, drop_count_o, order_err_o, retired_count_o} !== '0
        || out_pc_rdata_o !== 64'd0) begin
      bad++; $display("FAIL ares_status got o=%0b d=%0d r=%0d pc=%0h want 0",
        overflow_o, drop_count_o, retired_count_o, out_pc_rdata_o);
    end
    #1;
    rst_ni = 1'b1;
    clr();
    out_ready_i = 1'b1;
    lane(0, 64'd100);
    step();
    clr();
    total++;
    if (out_valid_o !== 1'b1 || out_order_o !== 64'd100 || order_err_o !== 1'b0) begin
      bad++; $display("FAIL ares_after got v=%0b o=%0d e=%0b want 1/100/0",
        out_valid_o, out_order_o, order_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_order_err();
    test_full_pop_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
